// File: rtl/alu_result_demux_if.sv
// Handshake and data bundle between the ALU result stream, the demux and the
// four per-operation consumers. Signal names follow the block's port list.
interface alu_result_demux_if #(
    parameter int WIDTH = 32
);
    // Valid/ready: a word moves on a rising clk edge exactly when valid and
    // ready are both 1; a producer holds valid and data stable until then.
    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           in_select;
    logic [WIDTH-1:0]     in_data;
    logic [3:0]           out_valid;
    logic [3:0]           out_ready;
    logic [4*WIDTH-1:0]   out_data;
    logic [31:0]          out_count;

    modport master (
        output in_valid, in_select, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_count
    );

    modport slave (
        input  in_valid, in_select, in_data, out_ready,
        output in_ready, out_valid, out_data, out_count
    );
endinterface

// File: rtl/alu_result_demux.sv
// Steers each ALU result word into one of four one-entry channels
// (00 AND, 01 ADD, 10 OR, 11 XOR) and counts delivered words per channel.
module alu_result_demux #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_result_demux_if.slave  bus
);

    logic [3:0]        r_full;
    logic [WIDTH-1:0]  r_hold [4];
    logic [7:0]        r_cnt  [4];

    logic              w_in_ready;
    logic              w_accept;
    logic [3:0]        w_drain;

    // A full channel can still accept when its consumer empties it this cycle.
    always_comb begin
        w_in_ready = rst_n & (~r_full[bus.in_select] | bus.out_ready[bus.in_select]);
    end

    assign w_accept     = bus.in_valid & w_in_ready;
    assign w_drain      = r_full & bus.out_ready;
    assign bus.in_ready = w_in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_full <= '0;
            for (int k = 0; k < 4; k++) begin
                r_hold[k] <= '0;
                r_cnt[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (w_drain[k]) begin
                    r_cnt[k] <= r_cnt[k] + 8'd1;
                end
                // Load wins over drain so a same-cycle refill leaves no bubble.
                if (w_accept && (bus.in_select == 2'(k))) begin
                    r_full[k] <= 1'b1;
                    r_hold[k] <= bus.in_data;
                end else if (w_drain[k]) begin
                    r_full[k] <= 1'b0;
                end
            end
        end
    end

    assign bus.out_valid = r_full;

    for (genvar g = 0; g < 4; g++) begin : g_pack
        assign bus.out_data[g*WIDTH +: WIDTH] = r_hold[g];
        assign bus.out_count[g*8 +: 8]        = r_cnt[g];
    end

endmodule

// File: tb/tb_alu_result_demux.sv
// Bench for alu_result_demux: directed scenarios plus random traffic,
// checked by a monitor against per-channel queues of words in flight.
module tb_alu_result_demux;

    localparam int W = 32;

    logic clk;
    logic rst_n;
    logic mon_en;

    alu_result_demux_if #(.WIDTH(W)) bus ();

    alu_result_demux #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q [4][$];
    logic [7:0]   cnt_m [4];
    int n_cmp;
    int n_fail;

    function automatic void chk(input string name, input logic [W-1:0] act,
                                input logic [W-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, req, $time);
        end
    endfunction

    // ---------------- monitor ----------------
    // Runs on the falling edge: compares the DUT against the queues, then
    // applies the transfers that the next rising edge will perform.
    always @(negedge clk) begin
        if (mon_en) begin
            logic exp_ir;
            exp_ir = rst_n && ((exp_q[bus.in_select].size() == 0) ||
                               bus.out_ready[bus.in_select]);
            chk("in_ready", W'(bus.in_ready), W'(exp_ir));
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("out_valid[%0d]", k), W'(bus.out_valid[k]),
                    W'(exp_q[k].size() != 0));
                if (exp_q[k].size() != 0)
                    chk($sformatf("out_data[%0d]", k), bus.out_data[k*W +: W], exp_q[k][0]);
                chk($sformatf("out_count[%0d]", k), W'(bus.out_count[k*8 +: 8]), W'(cnt_m[k]));
            end
            if (!rst_n) begin
                for (int k = 0; k < 4; k++) begin
                    exp_q[k].delete();
                    cnt_m[k] = 8'd0;
                end
            end else begin
                for (int k = 0; k < 4; k++) begin
                    if (exp_q[k].size() != 0 && bus.out_ready[k]) begin
                        void'(exp_q[k].pop_front());
                        cnt_m[k] = cnt_m[k] + 8'd1;
                    end
                end
            end
        end
    end

    // ---------------- driver ----------------
    // Entered and left just after a rising edge; pushes the expected word
    // on the edge where the DUT accepts it.
    task automatic send(input logic [1:0] sel, input logic [W-1:0] d);
        int n;
        bit acc;
        n   = 0;
        acc = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_select = sel;
        bus.in_data   = d;
        while (!acc && n < 300) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            if (acc) exp_q[sel].push_back(d);
            n++;
        end
        #1;
        bus.in_valid = 1'b0;
        if (!acc) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout actual=not_accepted required=accepted sel=%0d", sel);
        end
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit done;
        mon_en        = 1'b0;
        n_cmp         = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_select = 2'b00;
        bus.in_data   = '0;
        bus.out_ready = 4'b0000;
        for (int k = 0; k < 4; k++) cnt_m[k] = 8'd0;

        @(posedge clk); #1;
        mon_en = 1'b1;
        idle(1);
        rst_n = 1'b1;

        // Single ADD word, consumer always ready.
        bus.out_ready = 4'b1111;
        send(2'b01, 32'h0000_00FF);
        idle(3);
        chk("add_count_one", W'(bus.out_count[15:8]), 32'd1);
        chk("other_counts_zero", W'({bus.out_count[31:16], bus.out_count[7:0]}), 32'd0);

        // OR channel stalled, second word waits, then both move without a bubble.
        bus.out_ready = 4'b1011;
        fork
            begin
                send(2'b10, 32'hAAAA_AAAA);
                send(2'b10, 32'h5555_5555);
            end
            begin
                idle(6);
                bus.out_ready[2] = 1'b1;
            end
        join
        idle(3);

        // Back-to-back stream cycling all channels.
        bus.out_ready = 4'b1111;
        for (int i = 0; i < 8; i++) send(2'(i), $urandom());
        idle(3);

        // XOR stalled and full blocks input while AND still drains.
        bus.out_ready = 4'b0000;
        send(2'b11, 32'h1111_3333);
        send(2'b00, 32'h0000_0001);
        fork
            send(2'b11, 32'h3333_1111);
            begin
                idle(4);
                bus.out_ready[0] = 1'b1;
                idle(4);
                bus.out_ready[3] = 1'b1;
            end
        join
        idle(3);

        // 256 ADD words: counter wraps.
        bus.out_ready = 4'b1111;
        for (int i = 0; i < 256; i++) send(2'b01, $urandom());
        idle(3);

        // Reset while channels are full and a word is offered.
        bus.out_ready = 4'b0000;
        send(2'b00, 32'hC0DE_0000);
        send(2'b10, 32'hC0DE_0002);
        bus.in_valid  = 1'b1;
        bus.in_select = 2'b01;
        bus.in_data   = 32'hDEAD_BEEF;
        rst_n         = 1'b0;
        idle(1);
        rst_n         = 1'b1;
        bus.in_valid  = 1'b0;
        @(negedge clk);
        chk("post_reset_valid", W'(bus.out_valid), 32'd0);
        chk("post_reset_count", bus.out_count, 32'd0);
        idle(1);

        // Random traffic with randomly stalling consumers.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    send(2'($urandom_range(0, 3)), $urandom());
                    if ($urandom_range(0, 3) == 0) idle(1);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    bus.out_ready = 4'($urandom_range(0, 15));
                    idle(1);
                end
            end
        join

        bus.out_ready = 4'b1111;
        idle(4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("final_empty[%0d]", k), W'(exp_q[k].size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_result_demux.md
# alu_result_demux

Routing stage on the far side of the ALU result mux. It takes one result word plus the same 2-bit operation select and steers it into one of four per-operation output channels: 00 AND, 01 ADD, 10 OR, 11 XOR. Each channel is a one-entry holding register with a valid/ready handshake, and each channel keeps a count of delivered words. The block sits between the ALU datapath and the per-operation consumers (writeback and flag logic, trace capture).

## Interface
- WIDTH, 32, data word width in bits
- clk  input  1  rising-edge clock; the only clock
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  upstream word present
- in_ready  output  1  block accepts the word this cycle
- in_select  input  2  destination channel: 00 AND, 01 ADD, 10 OR, 11 XOR
- in_data  input  WIDTH  result word
- out_valid  output  4  bit k: channel k holds a word
- out_ready  input  4  bit k: consumer k takes the word this cycle
- out_data  output  4*WIDTH  channel k at bits [k*WIDTH +: WIDTH]
- out_count  output  32  delivered-word counter for channel k at bits [k*8 +: 8]

## Operation
- Per-channel state: full[k] (1 bit), hold[k] (WIDTH bits), cnt[k] (8 bits).
- out_valid[k] = full[k]. out_data slice k = hold[k]. out_count slice k = cnt[k].
- in_ready = rst_n & (~full[in_select] | out_ready[in_select]). This is combinational in in_select and out_ready.
- Accept occurs when in_valid & in_ready. On accept: hold[in_select] <= in_data and full[in_select] <= 1.
- Drain of channel k occurs when full[k] & out_ready[k]. On drain: cnt[k] <= cnt[k] + 1, wrapping from 255 to 0. full[k] <= 0 unless the same cycle also accepts into channel k.
- Same-channel drain and accept in one cycle: the old word is delivered, the new word is loaded, and full stays 1 (no bubble).
- Different channels operate independently. Any mix of drains across the four channels plus one accept is legal in a single cycle.
- Upstream holds in_valid, in_select and in_data stable until accepted. in_select may change freely while in_valid = 0.
- Only one word is accepted per cycle. A stall on the selected channel blocks input even if other channels are empty (no reordering).
- Reset is synchronous. On any clk edge with rst_n = 0: full = 0, hold = 0, cnt = 0. Held words are discarded and not counted.
- in_ready is 0 whenever rst_n = 0.

## Timing
- Latency: a word accepted at edge N is visible on out_valid/out_data after edge N, i.e. in cycle N+1.
- Throughput: 1 word/cycle when the consumer of the selected channel keeps out_ready = 1.
- Registered outputs: out_valid, out_data, out_count. Combinational output: in_ready.
- Reset values: out_valid = 0, out_data = 0, out_count = 0, in_ready = 0 while rst_n = 0.
- Reset mid-transfer: an accept or drain in the reset cycle has no effect. State after that edge equals the reset state.
- There is no combinational path from in_data to any output.

## Test plan
- Reset, then in_select=01, in_data=0x0000_00FF, in_valid=1 for one cycle, out_ready=1111 -> out_valid=0010 for exactly one cycle with ADD slice = 0x0000_00FF, then out_count ADD byte = 1; all other slices and counts stay 0.
- out_ready[2]=0; send 0xAAAA_AAAA then 0x5555_5555, both select 10 -> first word accepted, in_ready=0 while second is pending; raise out_ready[2] -> 0xAAAA_AAAA delivered and 0x5555_5555 loaded in the same cycle, out_valid[2] stays 1.
- Back-to-back stream of 8 words cycling select 00,01,10,11 with all out_ready=1 -> in_ready constantly 1, each word appears on the matching channel one cycle after acceptance, final counts 2,2,2,2.
- Channel 3 stalled (out_ready[3]=0) and full, input select=11 pending -> in_ready=0. Meanwhile channel 0 drains its held word, and its count still increments.
- 256 words to channel 1 with out_ready[1]=1 -> cnt[1] wraps to 0 after the 256th drain, and no other counter changes.
- Channels 0 and 2 full, counts 5 and 7; rst_n=0 for one edge while in_valid=1 -> after that edge out_valid=0000, all counts 0, in_ready was 0 during reset, and the input word is not accepted.
